// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : RX-side capture handshake plus host-side FIFO read port.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data_i;
    logic                  rx_ready_i;
    logic                  rx_clear_ready_o;
    logic                  pop_i;
    logic                  flush_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  full_o;
    logic [DEPTH_LOG2:0]   count_o;

    modport slave (
        input  rx_data_i, rx_ready_i, pop_i, flush_i,
        output rx_clear_ready_o, data_o, valid_o, full_o, count_o
    );

    modport master (
        output rx_data_i, rx_ready_i, pop_i, flush_i,
        input  rx_clear_ready_o, data_o, valid_o, full_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Acknowledges UartRx bytes once each and buffers them in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic        clock_i,
    input  wire logic        reset_i,
    uart_rx_fifo_if.slave    bus
);
    localparam int                  DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    clear_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic [DEPTH_LOG2:0]     count_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_capture;
    logic w_push;
    logic w_pop;

    assign w_full    = (count_q == c_FULL_COUNT);
    assign w_empty   = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign w_capture = (state_q == ST_IDLE) && bus.rx_ready_i && !w_full;
    assign w_push    = w_capture && !bus.flush_i;
    assign w_pop     = bus.pop_i && !w_empty;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            clear_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_capture) begin
                        state_q <= ST_CLEAR;
                        clear_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_GUARD;
                    clear_q <= 1'b0;
                end
                ST_GUARD: begin
                    state_q <= ST_IDLE;
                    clear_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    clear_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (bus.flush_i) begin
            count_d = '0;
        end else if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (bus.flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (w_push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.rx_data_i;
        end
    end

    // Storage is not reset; gating on empty keeps data_o at zero after reset.
    assign bus.data_o           = w_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.valid_o          = !w_empty;
    assign bus.full_o           = w_full;
    assign bus.count_o          = count_q;
    assign bus.rx_clear_ready_o = clear_q;
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer that sits directly downstream of UartRx.
- Consumes UartRx data_o/ready_o and returns single-cycle clear_ready pulses, so each received byte is acknowledged exactly once.
- Stores bytes in a first-word-fall-through FIFO behind a valid/pop interface for the host logic.
- Decouples host read latency from the serial byte rate, so back-to-back packets are not lost while the host is busy.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries).
- DATA_WIDTH, 8, byte width; must match UartRx data_o.

Ports:
- clock_i  in  1  system clock; all logic is on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- rx_data_i  in  DATA_WIDTH  connects to UartRx data_o.
- rx_ready_i  in  1  connects to UartRx ready_o.
- rx_clear_ready_o  out  1  connects to UartRx clear_ready_i; one-cycle acknowledge pulse.
- pop_i  in  1  host consumes the head entry this cycle.
- flush_i  in  1  synchronous FIFO empty request.
- data_o  out  DATA_WIDTH  head entry; valid only while valid_o=1.
- valid_o  out  1  FIFO not empty.
- full_o  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- count_o  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.

Behaviour:
- Interface: one clock (clock_i); reset_i is asynchronous and active-high.
- Reset values: rx_clear_ready_o=0, valid_o=0, full_o=0, count_o=0, data_o=0. Pointers are zeroed and the capture FSM returns to IDLE. Reset mid-capture abandons the acknowledge: the RX byte stays pending and is re-captured after reset.
- Capture FSM has three states; rx_clear_ready_o is registered and high only in CLEAR.
  - IDLE: if rx_ready_i=1 and full_o=0, write rx_data_i at the write pointer and go to CLEAR. Otherwise stay in IDLE.
  - CLEAR: rx_clear_ready_o=1 for exactly one cycle, then go to GUARD.
  - GUARD: rx_clear_ready_o=0 and rx_ready_i is ignored for one cycle, so the clear input sees a low phase before any later pulse. Then go to IDLE.
- Capture throughput is at most one byte per 3 clocks. This is far above any UART byte rate (at least 10 bit periods of at least 2 clocks each).
- Write latency: if rx_ready_i is sampled high in IDLE at edge N:
  - count_o increments at edge N.
  - An empty FIFO shows valid_o=1 and data_o=byte from edge N.
  - rx_clear_ready_o is high from edge N to edge N+1.
- Full backpressure: while full_o=1, the FSM holds in IDLE and does not pulse clear. The byte stays in UartRx with ready_o high. Further serial packets are dropped by UartRx itself; this block does not flag that loss.
- Full is evaluated on the registered count. A pop in the same cycle does not enable a push; the push happens the following cycle.
- Pop: pop_i=1 with valid_o=1 advances the read pointer at the edge. The next entry, if any, appears on data_o in the same edge's output. pop_i with valid_o=0 is ignored; count_o never underflows.
- Simultaneous push and pop: count_o is unchanged and both pointers advance. With count_o=1, valid_o stays 1 and data_o shows the pushed byte.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Occupancy is tracked by the count register; full_o = (count_o == 2^DEPTH_LOG2).
- flush_i takes priority over pop and push in the FIFO: pointers and count are zeroed.
  - An IDLE capture in the same cycle still transitions to CLEAR and acknowledges RX, but the byte is discarded.
  - flush_i does not affect the FSM.
- data_o is driven from the storage array at the read pointer. A registered-read or combinational-read implementation is acceptable provided the latencies above hold.

Test Plan:
- Single byte: drive rx_ready_i=1 with rx_data_i=0x55 until the pulse. Required: exactly one rx_clear_ready_o pulse, one cycle wide; valid_o=1, data_o=0x55, count_o=1; pop_i for one cycle returns count_o=0, valid_o=0.
- Ordering and wrap: push 0x00..0x17 while popping every 5th cycle. Required: pops return bytes in order across pointer wrap; count_o never exceeds 16.
- Full: push 16 bytes without pops, then hold rx_ready_i=1 with 0xAA. Required: full_o=1, rx_clear_ready_o stays 0. One pop, then 0xAA is captured with one pulse; full_o=1 again and the last entry read is 0xAA.
- One-shot guard: hold rx_ready_i=1 continuously with changing data. Required: clear pulses are separated by at least 2 low cycles and exactly one entry is written per pulse.
- Flush during capture: assert flush_i in the cycle rx_ready_i is accepted (byte 0xCC). Required: count_o=0, valid_o=0, one clear pulse still issued, 0xCC never appears on data_o.
- Async reset: assert reset_i while in CLEAR with 3 entries stored. Required: all outputs are 0 immediately without a clock edge. After release, the pending RX byte is re-captured with a fresh single pulse.
